xnumin: RTL and testbench

- Keyboard/switch number-entry peripheral; the input-side counterpart of the 7-segment number display.
- The user sets a BCD digit on 4 switches and presses buttons to shift digits in, toggle the sign, clear the entry and commit it.
- On commit, the block converts up to 3 BCD digits plus sign into an 11-bit two's-complement value (range −999..999).
- The CPU reads the value through the module-select/read strobe.

---
 rtl/xnumin_pkg.sv | 18 +
 rtl/xnumin_debounce.sv | 36 +++
 rtl/xnumin.sv | 116 +++++++++++
 tb/tb_xnumin.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/xnumin_pkg.sv
// xnumin_pkg: shared types and constants for the number-entry block and its display counterpart.
package xnumin_pkg;

    typedef enum logic [1:0] {IDLE, CONV, SIGN} state_t;

    localparam int NUM_W      = 11;
    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 3;

    localparam logic [BCD_W-1:0] BCD_MAX     = 4'd9;
    localparam logic [BCD_W-1:0] GLYPH_MINUS = 4'hA;
    localparam logic [BCD_W-1:0] GLYPH_BLANK = 4'hF;

    function automatic logic [9:0] mul10(input logic [9:0] a);
        return (a << 3) + (a << 1);
    endfunction

endpackage

// File: rtl/xnumin_debounce.sv
// xdebounce: 2-flop synchronizer, stability-window debouncer and rising-edge press pulse.
module xdebounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = sync[1] != level;
    assign flip   = differ && (cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            cnt   <= (differ && !flip) ? cnt + 1'b1 : '0;
            level <= flip ? sync[1] : level;
            pulse <= flip && sync[1];
        end
    end

endmodule

// File: rtl/xnumin.sv
// xnumin: switch/button number entry, converts sign + 3 BCD digits to 11-bit two's complement.
// Optional XNUMIN_ECHO_EN adds the live echo = {neg, H, T, O} output.
module xnumin
    import xnumin_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [BCD_W-1:0] sw,
    input  logic             btn_digit,
    input  logic             btn_sign,
    input  logic             btn_clr,
    input  logic             btn_enter,
    output logic [NUM_W-1:0] data_out,
    output logic             valid,
    output logic             busy
`ifdef XNUMIN_ECHO_EN
    ,
    output logic [12:0]      echo
`endif
);

    logic             p_digit, p_sign, p_clr, p_enter;
    logic [BCD_W-1:0] sw_m, sw_s;
    logic [BCD_W-1:0] h, t, o, dig;
    logic [1:0]       cnt, step;
    logic             neg;
    logic [9:0]       acc;
    logic [NUM_W-1:0] mag;
    state_t           state, state_nx;

    xdebounce #(.DB_CYCLES(DB_CYCLES)) u_db_digit (.clk(clk), .rst(rst), .din(btn_digit), .pulse(p_digit));
    xdebounce #(.DB_CYCLES(DB_CYCLES)) u_db_sign  (.clk(clk), .rst(rst), .din(btn_sign),  .pulse(p_sign));
    xdebounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr   (.clk(clk), .rst(rst), .din(btn_clr),   .pulse(p_clr));
    xdebounce #(.DB_CYCLES(DB_CYCLES)) u_db_enter (.clk(clk), .rst(rst), .din(btn_enter), .pulse(p_enter));

    assign dig = (step == 2'd0) ? h : (step == 2'd1) ? t : o;
    assign mag = {1'b0, acc};

`ifdef XNUMIN_ECHO_EN
    assign echo = {neg, h, t, o};
`endif

    always_comb begin
        state_nx = p_clr                           ? IDLE :
                   (state == IDLE && p_enter)      ? CONV :
                   (state == CONV && step == 2'd2) ? SIGN :
                   (state == SIGN)                 ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_m     <= '0;
            sw_s     <= '0;
            h        <= '0;
            t        <= '0;
            o        <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            step     <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            if (sel && valid) valid <= 1'b0;
            // clr wins over everything, in any state, and aborts a conversion
            if (p_clr) begin
                h     <= '0;
                t     <= '0;
                o     <= '0;
                cnt   <= '0;
                neg   <= 1'b0;
                valid <= 1'b0;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                if (p_enter) begin
                    acc  <= '0;
                    step <= '0;
                    busy <= 1'b1;
                end else if (p_digit) begin
                    if (sw_s <= BCD_MAX && cnt != 2'(MAX_DIGITS)) begin
                        h   <= t;
                        t   <= o;
                        o   <= sw_s;
                        cnt <= cnt + 1'b1;
                    end
                end else if (p_sign) begin
                    neg <= ~neg;
                end
            end else if (state == CONV) begin
                acc  <= mul10(acc) + {6'd0, dig};
                step <= step + 1'b1;
            end else begin
                data_out <= neg ? -mag : mag;
                valid    <= 1'b1;
                busy     <= 1'b0;
                h        <= '0;
                t        <= '0;
                o        <= '0;
                cnt      <= '0;
                neg      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xnumin.sv
// tb_xnumin: directed-vector bench for xnumin with a short debounce window.
module tb_xnumin;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  sw = '0;
    logic [3:0]  btn = '0;
    logic [10:0] data_out;
    logic        valid, busy;
    int          tests = 0;
    int          fails = 0;

    localparam int D = 0, S = 1, C = 2, E = 3;

    xnumin #(.DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sel(sel), .sw(sw),
        .btn_digit(btn[D]), .btn_sign(btn[S]), .btn_clr(btn[C]), .btn_enter(btn[E]),
        .data_out(data_out), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b, input int hold);
        @(posedge clk);
        #1 btn[b] = 1'b1;
        repeat (hold) @(posedge clk);
        #1 btn[b] = 1'b0;
    endtask

    task automatic tap(input int b, input logic [3:0] v);
        sw = v;
        idle(3);
        press(b, 6);
        idle(8);
    endtask

    task automatic wait_busy();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("busy_rise", {15'd0, busy}, 16'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            lat = n;
            if (valid) break;
        end
    endtask

    task automatic read();
        @(posedge clk);
        #1 sel = 1'b1;
        @(posedge clk);
        #1 sel = 1'b0;
        @(negedge clk);
    endtask

    int lat;

    initial begin
        #2;
        chk("rst_data", {5'd0, data_out}, 16'd0);
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        idle(2);
        rst = 1'b1;
        idle(2);

        tap(D, 4'd1); tap(D, 4'd2); tap(D, 4'd3);
        press(E, 6);
        wait_busy();
        wait_valid(lat);
        chk("lat_123", 16'(lat), 16'd4);
        chk("data_123", {5'd0, data_out}, 16'h07B);
        chk("valid_123", {15'd0, valid}, 16'd1);
        chk("busy_done", {15'd0, busy}, 16'd0);
        read();
        chk("valid_read", {15'd0, valid}, 16'd0);
        chk("data_held", {5'd0, data_out}, 16'h07B);
        idle(8);

        tap(D, 4'd9); tap(D, 4'd9); tap(D, 4'd9); tap(D, 4'd5); tap(S, 4'd0);
        press(E, 6);
        wait_busy();
        wait_valid(lat);
        chk("data_m999", {5'd0, data_out}, 16'h419);
        chk("valid_m999", {15'd0, valid}, 16'd1);
        read();
        idle(8);

        tap(S, 4'd0);
        press(E, 6);
        wait_busy();
        wait_valid(lat);
        chk("data_neg0", {5'd0, data_out}, 16'h000);
        chk("valid_neg0", {15'd0, valid}, 16'd1);
        read();
        idle(8);

        tap(D, 4'hA);
        sw = 4'd1;
        idle(3);
        press(D, 4);
        idle(8);
        press(D, 3);
        idle(8);
        press(E, 6);
        wait_busy();
        wait_valid(lat);
        chk("data_filter", {5'd0, data_out}, 16'd1);
        idle(8);

        tap(D, 4'd4); tap(D, 4'd5);
        @(posedge clk);
        #1 btn[E] = 1'b1;
        idle(2);
        btn[C] = 1'b1;
        idle(4);
        btn[E] = 1'b0;
        idle(2);
        btn[C] = 1'b0;
        idle(14);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_valid", {15'd0, valid}, 16'd0);
        chk("abort_data", {5'd0, data_out}, 16'd1);
        tap(D, 4'd7);
        press(E, 6);
        wait_busy();
        wait_valid(lat);
        chk("data_7", {5'd0, data_out}, 16'd7);
        chk("valid_7", {15'd0, valid}, 16'd1);
        read();
        idle(8);

        tap(D, 4'd8);
        press(E, 6);
        wait_busy();
        rst = 1'b0;
        #1;
        chk("rst_mid_data", {5'd0, data_out}, 16'd0);
        chk("rst_mid_valid", {15'd0, valid}, 16'd0);
        chk("rst_mid_busy", {15'd0, busy}, 16'd0);
        idle(2);
        rst = 1'b1;
        idle(10);

        tap(D, 4'd2);
        press(E, 6);
        wait_busy();
        repeat (3) @(posedge clk);
        #1 sel = 1'b1;
        @(posedge clk);
        #1 sel = 1'b0;
        @(negedge clk);
        chk("sel_sign_valid", {15'd0, valid}, 16'd1);
        chk("sel_sign_data", {5'd0, data_out}, 16'd2);
        read();
        chk("sel_after_valid", {15'd0, valid}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
